// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding, instruction size, default address width.
package cpu_pkg;
  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_BYTES = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_HI  = 3'd1,
    RD_LO  = 3'd2,
    CAP_LO = 3'd3,
    VALID  = 3'd4
  } fetch_state_e;
endpackage

// File: rtl/instr_fetch.sv
// Two-byte instruction fetch from byte-wide sync memory into a 16-bit IR with valid/ready.
// Optional IFETCH_FLUSH_EN adds a flush input that abandons any in-flight fetch.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int          ADDR_W     = ADDR_W_DEF,
  parameter bit          BIG_ENDIAN = 1'b1,
  parameter logic [15:0] IR_RESET   = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_req,
`ifdef IFETCH_FLUSH_EN
  input  logic              flush,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              pc_inc,
  output logic              busy
);

  localparam int IR_W      = 8 * INSTR_BYTES;
  // Byte at pc lands in lane 0, byte at pc+1 in lane 1.
  localparam int LANE0_LSB = BIG_ENDIAN ? 8 : 0;
  localparam int LANE1_LSB = BIG_ENDIAN ? 0 : 8;

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [IR_W-1:0]   r_ir;
  logic              w_flush;

`ifdef IFETCH_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_ir    <= IR_RESET;
    end else if (w_flush && (r_state != IDLE)) begin
      // Flush preempts any capture scheduled for this edge.
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (fetch_req) begin
            r_addr  <= pc;
            r_state <= RD_HI;
          end
        end
        RD_HI:  r_state <= RD_LO;
        RD_LO: begin
          r_ir[LANE0_LSB +: 8] <= mem_rdata;
          r_state              <= CAP_LO;
        end
        CAP_LO: begin
          r_ir[LANE1_LSB +: 8] <= mem_rdata;
          r_state              <= VALID;
        end
        VALID:   if (ir_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr = '0;
    mem_rd   = 1'b0;
    pc_inc   = 1'b0;
    ir_valid = 1'b0;
    busy     = (r_state != IDLE);
    case (r_state)
      RD_HI: begin
        mem_addr = r_addr;
        mem_rd   = 1'b1;
      end
      RD_LO: begin
        mem_addr = r_addr + ADDR_W'(1);
        mem_rd   = 1'b1;
      end
      CAP_LO:  pc_inc   = ~w_flush;
      VALID:   ir_valid = 1'b1;
      default: ;
    endcase
  end

  assign ir = r_ir;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: big- and little-endian instances share stimulus and a byte memory model.
module tb_instr_fetch;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_req = 1'b0;
  logic          ir_ready = 1'b0;
  logic [AW-1:0] pc = '0;
`ifdef IFETCH_FLUSH_EN
  logic          flush = 1'b0;
`endif

  logic [AW-1:0] be_addr, le_addr;
  logic          be_rd, le_rd, be_valid, le_valid, be_inc, le_inc, be_busy, le_busy;
  logic [7:0]    be_rdata = 8'h00, le_rdata = 8'h00;
  logic [15:0]   be_ir, le_ir;

  logic [7:0]    mem [256];
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (be_rd) be_rdata <= mem[be_addr];
    if (le_rd) le_rdata <= mem[le_addr];
  end

  instr_fetch #(.ADDR_W(AW), .BIG_ENDIAN(1'b1), .IR_RESET(16'h0000)) u_be (
    .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req),
`ifdef IFETCH_FLUSH_EN
    .flush(flush),
`endif
    .mem_addr(be_addr), .mem_rd(be_rd), .mem_rdata(be_rdata),
    .ir(be_ir), .ir_valid(be_valid), .ir_ready(ir_ready),
    .pc_inc(be_inc), .busy(be_busy)
  );

  instr_fetch #(.ADDR_W(AW), .BIG_ENDIAN(1'b0), .IR_RESET(16'h0000)) u_le (
    .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req),
`ifdef IFETCH_FLUSH_EN
    .flush(flush),
`endif
    .mem_addr(le_addr), .mem_rd(le_rd), .mem_rdata(le_rdata),
    .ir(le_ir), .ir_valid(le_valid), .ir_ready(ir_ready),
    .pc_inc(le_inc), .busy(le_busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One complete fetch from p with nready cycles of backpressure; ends in the IDLE cycle.
  // Expected control vector per cycle: {mem_rd, mem_addr, pc_inc, ir_valid, busy}.
  task automatic run_fetch(input logic [7:0] p, input int nready, input string nm);
    logic [7:0]  p1;
    logic [15:0] exp_be, exp_le;
    logic [11:0] expv, obs_be, obs_le;
    p1     = p + 8'd1;
    exp_be = {mem[p], mem[p1]};
    exp_le = {mem[p1], mem[p]};
    pc = p; fetch_req = 1'b1; ir_ready = 1'b0;
    for (int k = 1; k <= 4 + nready; k++) begin
      step;
      fetch_req = 1'($urandom_range(0, 1));
      pc        = 8'($urandom);
      ir_ready  = (k >= 4 + nready);
      case (k)
        1:       expv = {1'b1, p,     1'b0, 1'b0, 1'b1};
        2:       expv = {1'b1, p1,    1'b0, 1'b0, 1'b1};
        3:       expv = {1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        default: expv = {1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
      endcase
      obs_be = {be_rd, be_addr, be_inc, be_valid, be_busy};
      obs_le = {le_rd, le_addr, le_inc, le_valid, le_busy};
      checks++;
      if (obs_be !== expv || obs_le !== expv) begin
        failures++;
        $display("FAIL %s ctl cyc%0d: be=%h le=%h expected %h", nm, k, obs_be, obs_le, expv);
      end
      if (k >= 4) begin
        checks++;
        if (be_ir !== exp_be || le_ir !== exp_le) begin
          failures++;
          $display("FAIL %s ir cyc%0d: be=%h le=%h expected be=%h le=%h",
                   nm, k, be_ir, le_ir, exp_be, exp_le);
        end
      end
    end
    fetch_req = 1'b0;
    step;
    expv   = '0;
    obs_be = {be_rd, be_addr, be_inc, be_valid, be_busy};
    checks++;
    if (obs_be !== expv || be_ir !== exp_be || le_ir !== exp_le) begin
      failures++;
      $display("FAIL %s idle: ctl=%h ir be=%h le=%h expected ctl=%h ir be=%h le=%h",
               nm, obs_be, be_ir, le_ir, expv, exp_be, exp_le);
    end
    ir_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step; step;
    checks++;
    if ({be_rd, be_addr, be_inc, be_valid, be_busy} !== 12'h000 || be_ir !== 16'h0000 || le_ir !== 16'h0000) begin
      failures++;
      $display("FAIL reset_init: ctl=%h ir=%h/%h expected ctl=000 ir=0000", {be_rd, be_addr, be_inc, be_valid, be_busy}, be_ir, le_ir);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    mem[8'h10] = 8'hA5; mem[8'h11] = 8'h3C;
    run_fetch(8'h10, 0, "basic");
    checks++;
    if (be_ir !== 16'hA53C || le_ir !== 16'h3CA5) begin
      failures++;
      $display("FAIL basic_endian: be=%h le=%h expected be=a53c le=3ca5", be_ir, le_ir);
    end
  endtask

  task automatic test_reset_midfetch;
    pc = 8'h40; fetch_req = 1'b1;
    step;
    fetch_req = 1'b0;
    step;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step;
      checks++;
      if ({be_rd, be_addr, be_inc, be_valid, be_busy} !== 12'h000 || be_ir !== 16'h0000 || le_ir !== 16'h0000) begin
        failures++;
        $display("FAIL reset_mid%0d: ctl=%h ir=%h/%h expected ctl=000 ir=0000", i, {be_rd, be_addr, be_inc, be_valid, be_busy}, be_ir, le_ir);
      end
    end
    rst = 1'b0;
    step;
    checks++;
    if ({be_inc, be_busy, le_inc, le_busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_after: inc/busy=%b expected 0000", {be_inc, be_busy, le_inc, le_busy});
    end
  endtask

  task automatic test_wrap;
    mem[8'hFF] = 8'h12; mem[8'h00] = 8'h34;
    run_fetch(8'hFF, 0, "wrap");
    checks++;
    if (be_ir !== 16'h1234) begin
      failures++;
      $display("FAIL wrap_ir: got %h expected 1234", be_ir);
    end
  endtask

  task automatic test_backpressure;
    run_fetch(8'($urandom), 6, "backpressure");
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 16; n++)
      run_fetch(8'($urandom), int'($urandom_range(0, 3)), "b2b");
  endtask

`ifdef IFETCH_FLUSH_EN
  task automatic test_flush;
    pc = 8'h20; fetch_req = 1'b1;
    step;
    fetch_req = 1'b0;
    step; step;
    flush = 1'b1;
    #1;
    checks++;
    if (be_inc !== 1'b0 || le_inc !== 1'b0) begin
      failures++;
      $display("FAIL flush_pcinc: got %b%b expected 00", be_inc, le_inc);
    end
    step;
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({be_valid, be_busy, be_inc, le_valid, le_busy} !== 5'b00000) begin
        failures++;
        $display("FAIL flush_idle%0d: valid/busy/inc=%b expected 00000", i, {be_valid, be_busy, be_inc, le_valid, le_busy});
      end
      step;
    end
    run_fetch(8'h20, 0, "flush_refetch");
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset;
    test_basic;
    test_reset_midfetch;
    test_wrap;
    test_backpressure;
    test_back_to_back;
`ifdef IFETCH_FLUSH_EN
    test_flush;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
